stack_unit: RTL and testbench

- Memory-stage responder to the decode-stage push/pop protocol (enablePushOrPop, firstTimeCall, firstTimeRET).
- Owns the stack pointer and drives the data-memory port for PUSH and POP.
- Runs the two-cycle CALL sequence (push PC low half, then high half) and the two-cycle RET sequence (pop high half, then low half).
- On RET, delivers the reassembled 32-bit return PC to the fetch mux.

---
 rtl/stack_unit.sv | 172 +++++++++++++++++
 tb/tb_stack_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// Memory-stage stack unit: owns the stack pointer and sequences PUSH/POP/CALL/RET.
// Optional bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_unit #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned SP_RESET = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        enablePushOrPop,
    input  logic [1:0]        firstTimeCall,
    input  logic [1:0]        firstTimeRET,
    input  logic [DATA_W-1:0] pushData,
    input  logic [PC_W-1:0]   pcIn,
    input  logic [DATA_W-1:0] memRdData,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWrData,
    output logic              memWE,
    output logic              memRE,
    output logic [ADDR_W-1:0] spOut,
    output logic [DATA_W-1:0] popData,
    output logic              popValid,
    output logic [PC_W-1:0]   pcOut,
    output logic              pcLoad,
    output logic              protocolError,
    output logic              stackOverflow,
    output logic              stackUnderflow
);

    typedef enum logic [1:0] {IDLE, CALL_HI, RET_HI, RET_LO} state_t;

    localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] sp, sp_nx;
    logic [DATA_W-1:0] hi_hold, pc_hi, wr_data;
    logic              push_req, pop_req, push_blk, pop_blk;
    logic              do_wr, do_rd, wr_en, rd_en;
    logic              idle_proc, plain_pop, hi_load, perr, pc_set, pop_pend;

    assign push_req = (enablePushOrPop == 2'b01);
    assign pop_req  = (enablePushOrPop == 2'b11);

`ifdef STACK_BOUNDS_CHECK_EN
    assign push_blk = (sp == '0);
    assign pop_blk  = (sp == SP_INIT);
`else
    assign push_blk = 1'b0;
    assign pop_blk  = 1'b0;
`endif

    assign wr_en = do_wr & ~push_blk;
    assign rd_en = do_rd & ~pop_blk;
    assign sp_nx = wr_en ? sp - ADDR_W'(1) : (rd_en ? sp + ADDR_W'(1) : sp);
    assign spOut = sp;

    // Next-state and request decode; a broken CALL and the RET_LO tail fall through to IDLE handling
    always_comb begin
        state_nx  = IDLE;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        wr_data   = pushData;
        idle_proc = 1'b0;
        plain_pop = 1'b0;
        hi_load   = 1'b0;
        perr      = 1'b0;
        pc_set    = 1'b0;
        case (state)
            IDLE: idle_proc = 1'b1;
            CALL_HI: begin
                if (push_req && firstTimeCall == 2'b01) begin
                    do_wr   = 1'b1;
                    wr_data = hi_hold;
                end else begin
                    perr      = 1'b1;
                    idle_proc = 1'b1;
                end
            end
            RET_HI: begin
                if (pop_req && firstTimeRET == 2'b01) begin
                    do_rd    = 1'b1;
                    state_nx = pop_blk ? IDLE : RET_LO;
                end else begin
                    perr = 1'b1;
                end
            end
            RET_LO: begin
                pc_set    = 1'b1;
                idle_proc = 1'b1;
            end
            default: ;
        endcase
        if (idle_proc) begin
            if (push_req) begin
                do_wr = 1'b1;
                if (firstTimeCall == 2'b11) begin
                    wr_data  = pcIn[DATA_W-1:0];
                    hi_load  = ~push_blk;
                    state_nx = push_blk ? IDLE : CALL_HI;
                end
            end else if (pop_req) begin
                do_rd = 1'b1;
                if (firstTimeRET == 2'b11) begin
                    state_nx = pop_blk ? IDLE : RET_HI;
                end else begin
                    plain_pop = ~pop_blk;
                end
            end
        end
    end

    // Memory port, quiet while reset is held
    always_comb begin
        memAddr   = '0;
        memWrData = '0;
        memWE     = 1'b0;
        memRE     = 1'b0;
        if (!rst) begin
            if (wr_en) begin
                memAddr   = sp;
                memWrData = wr_data;
                memWE     = 1'b1;
            end else if (rd_en) begin
                memAddr = sp + ADDR_W'(1);
                memRE   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sp            <= SP_INIT;
            hi_hold       <= '0;
            pc_hi         <= '0;
            pop_pend      <= 1'b0;
            popData       <= '0;
            popValid      <= 1'b0;
            pcOut         <= '0;
            pcLoad        <= 1'b0;
            protocolError <= 1'b0;
        end else begin
            state         <= state_nx;
            sp            <= sp_nx;
            pop_pend      <= plain_pop;
            popValid      <= pop_pend;
            pcLoad        <= pc_set;
            protocolError <= perr;
            if (hi_load)         hi_hold <= DATA_W'(pcIn[PC_W-1:DATA_W]);
            if (state == RET_HI) pc_hi   <= memRdData;
            if (pop_pend)        popData <= memRdData;
            if (pc_set)          pcOut   <= PC_W'({pc_hi, memRdData});
        end
    end

`ifdef STACK_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stackOverflow  <= 1'b0;
            stackUnderflow <= 1'b0;
        end else begin
            if (do_wr && push_blk) stackOverflow  <= 1'b1;
            if (do_rd && pop_blk)  stackUnderflow <= 1'b1;
        end
    end
`else
    assign stackOverflow  = 1'b0;
    assign stackUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: a transaction-level stack model with an event schedule
// is checked every cycle, plus hand-computed literal checks.
module tb_stack_unit;

    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned PC_W     = 32;
    localparam int unsigned SP_RESET = 2047;
    localparam int          DEPTH    = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        en = 2'b00, ftc = 2'b00, ftr = 2'b00;
    logic [DATA_W-1:0] push_data = '0;
    logic [PC_W-1:0]   pc_in = '0;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic [ADDR_W-1:0] mem_addr, sp_out;
    logic [DATA_W-1:0] mem_wr_data, pop_data;
    logic              mem_we, mem_re, pop_valid, pc_load, proto_err, ovf, unf;
    logic [PC_W-1:0]   pc_out;

    int n_checks = 0;
    int n_fail   = 0;

    stack_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PC_W(PC_W), .SP_RESET(SP_RESET)) dut (
        .clk(clk), .rst(rst), .enablePushOrPop(en), .firstTimeCall(ftc), .firstTimeRET(ftr),
        .pushData(push_data), .pcIn(pc_in), .memRdData(mem_rd_data),
        .memAddr(mem_addr), .memWrData(mem_wr_data), .memWE(mem_we), .memRE(mem_re),
        .spOut(sp_out), .popData(pop_data), .popValid(pop_valid), .pcOut(pc_out),
        .pcLoad(pc_load), .protocolError(proto_err),
        .stackOverflow(ovf), .stackUnderflow(unf)
    );

    always #5 clk = ~clk;

    // Environment memory with one-cycle read latency
    logic [DATA_W-1:0] tb_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_re) mem_rd_data <= tb_mem[mem_addr];
        if (mem_we) tb_mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    logic [DATA_W-1:0] m_mem [0:DEPTH-1];
    int                m_sp = SP_RESET;
    int                m_mode = 0;          // 0 free, 1 CALL high half owed, 2 RET second pop owed
    logic [DATA_W-1:0] m_hi_hold = '0, m_ret_hi = '0;
    bit                m_ovf = 0, m_unf = 0, model_ok = 0;
    // Scheduled visible events: slot 0 = next cycle, slot 1 = cycle after that
    bit                q_pv [2], q_pl [2], q_pe [2];
    logic [DATA_W-1:0] q_pd [2];
    logic [PC_W-1:0]   q_pc [2];
    logic [DATA_W-1:0] e_pd = '0;
    logic [PC_W-1:0]   e_pc = '0;
    bit                e_pv = 0, e_pl = 0, e_pe = 0, e_ovf = 0, e_unf = 0;
    int                e_sp = SP_RESET;
    bit                c_we, c_re;
    int                c_addr;
    logic [DATA_W-1:0] c_wd;

    task automatic m_push(input logic [DATA_W-1:0] d, output bit ok);
        if (BOUNDS && m_sp == 0) begin
            m_ovf = 1; ok = 0;
        end else begin
            c_we = 1; c_addr = m_sp; c_wd = d;
            m_mem[m_sp] = d;
            m_sp = (m_sp + DEPTH - 1) % DEPTH;
            ok = 1;
        end
    endtask

    task automatic m_pop(output logic [DATA_W-1:0] w, output bit ok);
        w = '0;
        if (BOUNDS && m_sp == SP_RESET) begin
            m_unf = 1; ok = 0;
        end else begin
            m_sp = (m_sp + 1) % DEPTH;
            c_re = 1; c_addr = m_sp;
            w = m_mem[m_sp];
            ok = 1;
        end
    endtask

    always @(negedge clk) begin
        bit                ok, fresh, push, pop;
        logic [DATA_W-1:0] w;
        if (model_ok) begin
            chk("spOut", 32'(sp_out), 32'(e_sp));
            chk("popValid", 32'(pop_valid), 32'(e_pv));
            chk("popData", 32'(pop_data), 32'(e_pd));
            chk("pcLoad", 32'(pc_load), 32'(e_pl));
            chk("pcOut", pc_out, e_pc);
            chk("protocolError", 32'(proto_err), 32'(e_pe));
            chk("stackOverflow", 32'(ovf), 32'(e_ovf));
            chk("stackUnderflow", 32'(unf), 32'(e_unf));
        end
        for (int i = 0; i < 1; i++) begin
            q_pv[i] = q_pv[i+1]; q_pl[i] = q_pl[i+1]; q_pe[i] = q_pe[i+1];
            q_pd[i] = q_pd[i+1]; q_pc[i] = q_pc[i+1];
        end
        q_pv[1] = 0; q_pl[1] = 0; q_pe[1] = 0;
        c_we = 0; c_re = 0; c_addr = 0; c_wd = '0;
        if (rst) begin
            m_sp = SP_RESET; m_mode = 0; m_ovf = 0; m_unf = 0;
            q_pv = '{0, 0}; q_pl = '{0, 0}; q_pe = '{0, 0};
            e_pd = '0; e_pc = '0;
            model_ok = 1;
        end else begin
            push  = (en == 2'b01);
            pop   = (en == 2'b11);
            fresh = 1;
            if (m_mode == 1) begin
                m_mode = 0;
                if (push && ftc == 2'b01) begin
                    fresh = 0;
                    m_push(m_hi_hold, ok);
                end else begin
                    q_pe[0] = 1;
                end
            end else if (m_mode == 2) begin
                m_mode = 0;
                fresh  = 0;
                if (pop && ftr == 2'b01) begin
                    m_pop(w, ok);
                    if (ok) begin q_pl[1] = 1; q_pc[1] = {m_ret_hi, w}; end
                end else begin
                    q_pe[0] = 1;
                end
            end
            if (fresh) begin
                if (push) begin
                    if (ftc == 2'b11) begin
                        m_push(pc_in[15:0], ok);
                        if (ok) begin m_hi_hold = pc_in[31:16]; m_mode = 1; end
                    end else begin
                        m_push(push_data, ok);
                    end
                end else if (pop) begin
                    m_pop(w, ok);
                    if (ok) begin
                        if (ftr == 2'b11) begin m_ret_hi = w; m_mode = 2; end
                        else begin q_pv[1] = 1; q_pd[1] = w; end
                    end
                end
            end
        end
        chk("memWE", 32'(mem_we), 32'(c_we));
        chk("memRE", 32'(mem_re), 32'(c_re));
        chk("memAddr", 32'(mem_addr), 32'(c_addr));
        chk("memWrData", 32'(mem_wr_data), 32'(c_wd));
        e_sp = m_sp; e_ovf = m_ovf; e_unf = m_unf;
        e_pv = q_pv[0]; e_pl = q_pl[0]; e_pe = q_pe[0];
        if (q_pv[0]) e_pd = q_pd[0];
        if (q_pl[0]) e_pc = q_pc[0];
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic [1:0] e, input logic [1:0] c, input logic [1:0] t,
                       input logic [DATA_W-1:0] pd, input logic [PC_W-1:0] pc);
        @(posedge clk);
        #1;
        rst = r; en = e; ftc = c; ftr = t; push_data = pd; pc_in = pc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'b00, 2'b00, 2'b00, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin tb_mem[i] = '0; m_mem[i] = '0; end
        q_pv = '{0, 0}; q_pl = '{0, 0}; q_pe = '{0, 0};
        q_pd = '{16'h0, 16'h0}; q_pc = '{32'h0, 32'h0};

        // Reset, with a pop requested while reset is held
        cyc(1, 2'b11, 2'b00, 2'b00, '0, '0);
        cyc(1, 2'b00, 2'b00, 2'b00, '0, '0);
        #1 chk("rst_sp", 32'(sp_out), 32'd2047);
        chk("rst_pcOut", pc_out, 32'h0);

        // Plain push then pop
        cyc(0, 2'b01, 2'b00, 2'b00, 16'hABCD, '0);
        #1 chk("push_addr", 32'(mem_addr), 32'd2047);
        chk("push_data", 32'(mem_wr_data), 32'hABCD);
        chk("push_we", 32'(mem_we), 32'd1);
        cyc(0, 2'b11, 2'b00, 2'b00, '0, '0);
        #1 chk("push_sp", 32'(sp_out), 32'd2046);
        chk("pop_re", 32'(mem_re), 32'd1);
        chk("pop_addr", 32'(mem_addr), 32'd2047);
        idle(1);
        #1 chk("pop_sp", 32'(sp_out), 32'd2047);
        idle(1);
        #1 chk("pop_valid", 32'(pop_valid), 32'd1);
        chk("pop_value", 32'(pop_data), 32'hABCD);
        idle(1);
        #1 chk("pop_valid_pulse", 32'(pop_valid), 32'd0);

        // CALL with pcIn changing in the second cycle, then RET
        cyc(0, 2'b01, 2'b11, 2'b00, '0, 32'h0001_0234);
        #1 chk("call_lo", 32'(mem_wr_data), 32'h0234);
        cyc(0, 2'b01, 2'b01, 2'b00, '0, 32'hFFFF_FFFF);
        #1 chk("call_hi", 32'(mem_wr_data), 32'h0001);
        chk("call_hi_addr", 32'(mem_addr), 32'd2046);
        cyc(0, 2'b11, 2'b00, 2'b11, '0, '0);
        #1 chk("call_sp", 32'(sp_out), 32'd2045);
        chk("ret_addr1", 32'(mem_addr), 32'd2046);
        cyc(0, 2'b11, 2'b00, 2'b01, '0, '0);
        #1 chk("ret_addr2", 32'(mem_addr), 32'd2047);
        idle(1);
        #1 chk("ret_sp", 32'(sp_out), 32'd2047);
        idle(1);
        #1 chk("ret_load", 32'(pc_load), 32'd1);
        chk("ret_pc", pc_out, 32'h0001_0234);
        idle(1);

        // CALL first half followed by a plain push
        cyc(0, 2'b01, 2'b11, 2'b00, '0, 32'h1234_5678);
        cyc(0, 2'b01, 2'b00, 2'b00, 16'h5555, '0);
        #1 chk("perr_push_addr", 32'(mem_addr), 32'd2046);
        chk("perr_push_data", 32'(mem_wr_data), 32'h5555);
        idle(1);
        #1 chk("perr_call", 32'(proto_err), 32'd1);
        chk("perr_call_sp", 32'(sp_out), 32'd2045);

        // RET first half abandoned
        cyc(0, 2'b11, 2'b00, 2'b11, '0, '0);
        idle(1);
        idle(1);
        #1 chk("perr_ret", 32'(proto_err), 32'd1);
        cyc(0, 2'b11, 2'b00, 2'b00, '0, '0);

        // Three pushes, RET, then a plain pop issued in the RET tail cycle
        cyc(0, 2'b01, 2'b00, 2'b00, 16'h1111, '0);
        cyc(0, 2'b01, 2'b00, 2'b00, 16'h2222, '0);
        cyc(0, 2'b01, 2'b00, 2'b00, 16'h3333, '0);
        cyc(0, 2'b11, 2'b00, 2'b11, '0, '0);
        cyc(0, 2'b11, 2'b00, 2'b01, '0, '0);
        cyc(0, 2'b11, 2'b00, 2'b00, '0, '0);
        idle(1);
        #1 chk("tail_pc", pc_out, 32'h3333_2222);
        idle(1);
        #1 chk("tail_pop", 32'(pop_data), 32'h1111);
        idle(1);

        // Reset while in RET_HI
        cyc(0, 2'b01, 2'b11, 2'b00, '0, 32'hCAFE_BEEF);
        cyc(0, 2'b01, 2'b01, 2'b00, '0, '0);
        cyc(0, 2'b11, 2'b00, 2'b11, '0, '0);
        cyc(1, 2'b11, 2'b00, 2'b01, '0, '0);
        idle(1);
        #1 chk("abort_sp", 32'(sp_out), 32'd2047);
        idle(2);
        #1 chk("abort_load", 32'(pc_load), 32'd0);

        // Pop at the top of the stack
        cyc(0, 2'b11, 2'b00, 2'b00, '0, '0);
`ifdef STACK_BOUNDS_CHECK_EN
        #1 chk("udf_re", 32'(mem_re), 32'd0);
        idle(1);
        #1 chk("udf_sp", 32'(sp_out), 32'd2047);
        chk("udf_flag", 32'(unf), 32'd1);
        idle(2);
        #1 chk("udf_held", 32'(unf), 32'd1);
        chk("udf_no_valid", 32'(pop_valid), 32'd0);
        for (int i = 0; i < 2048; i++) cyc(0, 2'b01, 2'b00, 2'b00, 16'(i), '0);
        idle(1);
        #1 chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_sp", 32'(sp_out), 32'd0);
`else
        #1 chk("wrap_addr", 32'(mem_addr), 32'd0);
        idle(1);
        #1 chk("wrap_sp", 32'(sp_out), 32'd0);
        cyc(0, 2'b01, 2'b00, 2'b00, 16'h7777, '0);
        #1 chk("wrap_push_addr", 32'(mem_addr), 32'd0);
        idle(1);
        #1 chk("wrap_back_sp", 32'(sp_out), 32'd2047);
`endif
        idle(3);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
